// File: rtl/cpu_ctrl_fsm.sv
// cpu_ctrl_fsm: multi-cycle control sequencer for the single-issue ARM datapath.
// Fetches over a req/ack handshake, evaluates the condition field against
// NZCV, drives ALU/regfile/PC strobes and sequences data-memory access.
// A memory handshake that is not acknowledged within MEM_TIMEOUT cycles
// parks the sequencer in FAULT until reset (MEM_TIMEOUT = 0 disables this).
// Optional: define CTRL_PERF_CNT_EN to implement retire_count; otherwise it
// reads as zero and the counter is not built.
module cpu_ctrl_fsm #(
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        nreset,
  input  logic        run,
  output logic        imem_req,
  input  logic        imem_ack,
  input  logic [31:0] instr,
  input  logic [3:0]  flags,
  output logic        ir_load,
  output logic [3:0]  alu_op,
  output logic        alu_src_imm,
  output logic        set_flags,
  output logic        dmem_req,
  output logic        dmem_we,
  input  logic        dmem_ack,
  output logic        rf_we,
  output logic [3:0]  rf_waddr,
  output logic        pc_en,
  output logic        branch_take,
  output logic        fault,
  output logic [2:0]  state,
  output logic [15:0] retire_count
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_FAULT  = 3'd6
  } state_e;

  localparam logic [7:0] TO_LIM = 8'(MEM_TIMEOUT);

  state_e      state_q, state_d;
  logic [31:0] ir_q, ir_d;
  logic [7:0]  to_cnt_q, to_cnt_d;
  logic        skip_q, skip_d;

  logic is_dp, is_ls, is_b;
  logic cond_pass;
  logic timeout_hit;
  logic fl_n, fl_z, fl_c, fl_v;

  // Operand/shift fields of the IR are consumed by the datapath, not here.
  logic unused_ir_bits;
  assign unused_ir_bits = ^{ir_q[19:16], ir_q[11:0]};

  assign {fl_n, fl_z, fl_c, fl_v} = flags;
  assign state       = state_q;
  assign timeout_hit = (TO_LIM != '0) && (to_cnt_q == TO_LIM - 8'd1);

  // Instruction class decode from IR[27:25].
  always_comb begin
    is_dp = (ir_q[27:26] == 2'b00);
    is_ls = (ir_q[27:26] == 2'b01);
    is_b  = (ir_q[27:25] == 3'b101);
  end

  // ARM condition-code evaluation; 1111 is treated as never.
  always_comb begin
    cond_pass = 1'b0;
    unique case (ir_q[31:28])
      4'b0000: cond_pass = fl_z;
      4'b0001: cond_pass = !fl_z;
      4'b0010: cond_pass = fl_c;
      4'b0011: cond_pass = !fl_c;
      4'b0100: cond_pass = fl_n;
      4'b0101: cond_pass = !fl_n;
      4'b0110: cond_pass = fl_v;
      4'b0111: cond_pass = !fl_v;
      4'b1000: cond_pass = fl_c && !fl_z;
      4'b1001: cond_pass = !fl_c || fl_z;
      4'b1010: cond_pass = (fl_n == fl_v);
      4'b1011: cond_pass = (fl_n != fl_v);
      4'b1100: cond_pass = !fl_z && (fl_n == fl_v);
      4'b1101: cond_pass = fl_z || (fl_n != fl_v);
      4'b1110: cond_pass = 1'b1;
      default: cond_pass = 1'b0;
    endcase
  end

  // Next-state, IR capture, timeout counting and strobe decode.
  always_comb begin
    state_d     = state_q;
    ir_d        = ir_q;
    skip_d      = skip_q;
    to_cnt_d    = to_cnt_q;
    imem_req    = 1'b0;
    ir_load     = 1'b0;
    alu_op      = '0;
    alu_src_imm = 1'b0;
    set_flags   = 1'b0;
    dmem_req    = 1'b0;
    dmem_we     = 1'b0;
    rf_we       = 1'b0;
    rf_waddr    = '0;
    pc_en       = 1'b0;
    branch_take = 1'b0;
    fault       = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (run) state_d = S_FETCH;
      end
      S_FETCH: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          ir_load = 1'b1;
          ir_d    = instr;
          state_d = S_DECODE;
        end else if (timeout_hit) begin
          state_d = S_FAULT;
        end else begin
          to_cnt_d = to_cnt_q + 8'd1;
        end
      end
      S_DECODE: begin
        skip_d  = !cond_pass;
        state_d = cond_pass ? S_EXEC : S_WB;
      end
      S_EXEC: begin
        if (is_dp) begin
          alu_op      = ir_q[24:21];
          alu_src_imm = ir_q[25];
          set_flags   = ir_q[20];
          state_d     = S_WB;
        end else if (is_ls) begin
          state_d = S_MEM;
        end else if (is_b) begin
          branch_take = 1'b1;
          state_d     = S_FETCH;
        end else begin
          state_d = S_WB;
        end
      end
      S_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = !ir_q[20];
        if (dmem_ack) begin
          state_d = S_WB;
        end else if (timeout_hit) begin
          state_d = S_FAULT;
        end else begin
          to_cnt_d = to_cnt_q + 8'd1;
        end
      end
      S_WB: begin
        pc_en    = 1'b1;
        rf_we    = !skip_q && ((is_dp && (ir_q[24:23] != 2'b10)) ||
                               (is_ls && ir_q[20]));
        rf_waddr = rf_we ? ir_q[15:12] : 4'd0;
        state_d  = run ? S_FETCH : S_IDLE;
      end
      S_FAULT: begin
        fault = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
    // Any state change clears the counter, which covers entry to FETCH/MEM.
    if (state_d != state_q) to_cnt_d = '0;
  end

  // Control state registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (nreset) begin
      state_q  <= S_IDLE;
      ir_q     <= '0;
      to_cnt_q <= '0;
      skip_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      ir_q     <= ir_d;
      to_cnt_q <= to_cnt_d;
      skip_q   <= skip_d;
    end
  end

`ifdef CTRL_PERF_CNT_EN
  logic [15:0] retire_q, retire_d;

  // Retire counter advances once per WB cycle, wrapping at 16 bits.
  always_comb begin
    retire_d = retire_q;
    if (state_q == S_WB) retire_d = retire_q + 16'd1;
  end

  // Retire counter register.
  always_ff @(posedge clk) begin
    if (nreset) retire_q <= '0;
    else        retire_q <= retire_d;
  end

  assign retire_count = retire_q;
`else
  assign retire_count = '0;
`endif

endmodule

// File: tb/tb_cpu_ctrl_fsm.sv
// tb_cpu_ctrl_fsm: directed bench for cpu_ctrl_fsm with hand-computed expectations.
// Strobe vector order: {imem_req, ir_load, set_flags, dmem_req, dmem_we,
//                       rf_we, pc_en, branch_take, fault}
module tb_cpu_ctrl_fsm;

`ifdef CTRL_PERF_CNT_EN
  localparam bit PERF_EN = 1'b1;
`else
  localparam bit PERF_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        nreset, run, imem_ack, dmem_ack;
  logic [31:0] instr;
  logic [3:0]  flags;
  logic        imem_req, ir_load, alu_src_imm, set_flags, dmem_req, dmem_we;
  logic        rf_we, pc_en, branch_take, fault;
  logic [3:0]  alu_op, rf_waddr;
  logic [2:0]  state;
  logic [15:0] retire_count;
  logic [8:0]  strb;

  int unsigned checks = 0;
  int unsigned errors = 0;
  logic [15:0] exp_ret = 16'd0;
  logic [15:0] ret_exp;

  cpu_ctrl_fsm #(.MEM_TIMEOUT(16)) dut (
    .clk(clk), .nreset(nreset), .run(run),
    .imem_req(imem_req), .imem_ack(imem_ack), .instr(instr), .flags(flags),
    .ir_load(ir_load), .alu_op(alu_op), .alu_src_imm(alu_src_imm),
    .set_flags(set_flags), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_ack(dmem_ack), .rf_we(rf_we), .rf_waddr(rf_waddr), .pc_en(pc_en),
    .branch_take(branch_take), .fault(fault), .state(state),
    .retire_count(retire_count)
  );

  always #5 clk = ~clk;

  assign strb = {imem_req, ir_load, set_flags, dmem_req, dmem_we,
                 rf_we, pc_en, branch_take, fault};

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Present a word with ack in the current FETCH cycle; returns in DECODE.
  task automatic fetch(input logic [31:0] w);
    instr    = w;
    imem_ack = 1'b1;
    tick();
    imem_ack = 1'b0;
    instr    = '0;
  endtask

  task automatic test_reset();
    nreset = 1'b1; run = 1'b1; imem_ack = 1'b0; dmem_ack = 1'b0;
    instr = '0; flags = '0;
    tick(); tick();
    checks++; if (state !== 3'd0) begin errors++; $display("FAIL reset_state: got %0d exp 0", state); end
    checks++; if (strb !== 9'b000000000) begin errors++; $display("FAIL reset_strobes: got %b exp 000000000", strb); end
    ret_exp = 16'd0;
    checks++; if (retire_count !== ret_exp) begin errors++; $display("FAIL reset_retire: got %0d exp %0d", retire_count, ret_exp); end
    nreset = 1'b0;
    tick();
    checks++; if (state !== 3'd1) begin errors++; $display("FAIL release_state: got %0d exp 1", state); end
    checks++; if (strb !== 9'b100000000) begin errors++; $display("FAIL release_strobes: got %b exp 100000000", strb); end
  endtask

  task automatic test_dp_add();
    instr = 32'hE0843003; imem_ack = 1'b1;
    #1;
    checks++; if (strb !== 9'b110000000) begin errors++; $display("FAIL add_fetch_strobes: got %b exp 110000000", strb); end
    tick();
    imem_ack = 1'b0; instr = '0;
    checks++; if (state !== 3'd2) begin errors++; $display("FAIL add_decode_state: got %0d exp 2", state); end
    checks++; if (strb !== 9'b000000000) begin errors++; $display("FAIL add_decode_strobes: got %b exp 000000000", strb); end
    tick();
    checks++; if (state !== 3'd3) begin errors++; $display("FAIL add_exec_state: got %0d exp 3", state); end
    checks++; if ({alu_op, alu_src_imm} !== 5'b0100_0) begin errors++; $display("FAIL add_exec_alu: got %b exp 01000", {alu_op, alu_src_imm}); end
    checks++; if (strb !== 9'b000000000) begin errors++; $display("FAIL add_exec_strobes: got %b exp 000000000", strb); end
    tick();
    checks++; if (state !== 3'd5) begin errors++; $display("FAIL add_wb_state: got %0d exp 5", state); end
    checks++; if (strb !== 9'b000001100) begin errors++; $display("FAIL add_wb_strobes: got %b exp 000001100", strb); end
    checks++; if (rf_waddr !== 4'd3) begin errors++; $display("FAIL add_wb_waddr: got %0d exp 3", rf_waddr); end
    tick();
    exp_ret++;
    ret_exp = PERF_EN ? exp_ret : 16'd0;
    checks++; if (state !== 3'd1) begin errors++; $display("FAIL add_next_state: got %0d exp 1", state); end
    checks++; if (retire_count !== ret_exp) begin errors++; $display("FAIL add_retire: got %0d exp %0d", retire_count, ret_exp); end
  endtask

  task automatic test_cond_skip();
    flags = 4'b0000;
    fetch(32'h00843003);
    tick();
    checks++; if (state !== 3'd5) begin errors++; $display("FAIL skip_wb_state: got %0d exp 5", state); end
    checks++; if (strb !== 9'b000000100) begin errors++; $display("FAIL skip_wb_strobes: got %b exp 000000100", strb); end
    checks++; if (rf_waddr !== 4'd0) begin errors++; $display("FAIL skip_wb_waddr: got %0d exp 0", rf_waddr); end
    tick();
    exp_ret++;
    ret_exp = PERF_EN ? exp_ret : 16'd0;
    checks++; if (state !== 3'd1) begin errors++; $display("FAIL skip_next_state: got %0d exp 1", state); end
    checks++; if (retire_count !== ret_exp) begin errors++; $display("FAIL skip_retire: got %0d exp %0d", retire_count, ret_exp); end
    flags = 4'b0100;
    fetch(32'h00843003);
    tick();
    checks++; if (state !== 3'd3) begin errors++; $display("FAIL eq_exec_state: got %0d exp 3", state); end
    tick();
    checks++; if (strb !== 9'b000001100) begin errors++; $display("FAIL eq_wb_strobes: got %b exp 000001100", strb); end
    checks++; if (rf_waddr !== 4'd3) begin errors++; $display("FAIL eq_wb_waddr: got %0d exp 3", rf_waddr); end
    tick();
    exp_ret++;
    flags = 4'b0000;
  endtask

  task automatic test_ldr_str();
    int unsigned req_cycles;
    fetch(32'hE5912000);
    tick();
    tick();
    req_cycles = 0;
    for (int i = 0; i < 3; i++) begin
      if (i == 2) dmem_ack = 1'b1;
      #1;
      checks++; if (state !== 3'd4 || strb !== 9'b000100000) begin errors++; $display("FAIL ldr_mem_cycle%0d: got state %0d strb %b exp state 4 strb 000100000", i, state, strb); end
      if (dmem_req) req_cycles++;
      tick();
    end
    dmem_ack = 1'b0;
    checks++; if (req_cycles != 3) begin errors++; $display("FAIL ldr_req_cycles: got %0d exp 3", req_cycles); end
    checks++; if (state !== 3'd5 || strb !== 9'b000001100) begin errors++; $display("FAIL ldr_wb: got state %0d strb %b exp state 5 strb 000001100", state, strb); end
    checks++; if (rf_waddr !== 4'd2) begin errors++; $display("FAIL ldr_wb_waddr: got %0d exp 2", rf_waddr); end
    tick();
    exp_ret++;
    fetch(32'hE5812000);
    tick();
    tick();
    dmem_ack = 1'b1;
    #1;
    checks++; if (state !== 3'd4 || strb !== 9'b000110000) begin errors++; $display("FAIL str_mem: got state %0d strb %b exp state 4 strb 000110000", state, strb); end
    tick();
    dmem_ack = 1'b0;
    checks++; if (state !== 3'd5 || strb !== 9'b000000100) begin errors++; $display("FAIL str_wb: got state %0d strb %b exp state 5 strb 000000100", state, strb); end
    tick();
    exp_ret++;
  endtask

  task automatic test_cmp_branch();
    fetch(32'hE1530004);
    tick();
    checks++; if (strb !== 9'b001000000 || alu_op !== 4'b1010) begin errors++; $display("FAIL cmp_exec: got strb %b alu_op %b exp strb 001000000 alu_op 1010", strb, alu_op); end
    tick();
    checks++; if (state !== 3'd5 || strb !== 9'b000000100) begin errors++; $display("FAIL cmp_wb: got state %0d strb %b exp state 5 strb 000000100", state, strb); end
    tick();
    exp_ret++;
    fetch(32'hEA000000);
    tick();
    checks++; if (state !== 3'd3 || strb !== 9'b000000010) begin errors++; $display("FAIL b_exec: got state %0d strb %b exp state 3 strb 000000010", state, strb); end
    tick();
    ret_exp = PERF_EN ? exp_ret : 16'd0;
    checks++; if (state !== 3'd1 || strb !== 9'b100000000) begin errors++; $display("FAIL b_next: got state %0d strb %b exp state 1 strb 100000000", state, strb); end
    checks++; if (retire_count !== ret_exp) begin errors++; $display("FAIL b_retire: got %0d exp %0d", retire_count, ret_exp); end
  endtask

  task automatic test_timeout();
    for (int i = 1; i <= 16; i++) begin
      checks++; if (state !== 3'd1) begin errors++; $display("FAIL to_fetch_cycle%0d: got state %0d exp 1", i, state); end
      tick();
    end
    checks++; if (state !== 3'd6 || strb !== 9'b000000001) begin errors++; $display("FAIL to_fault: got state %0d strb %b exp state 6 strb 000000001", state, strb); end
    tick(); tick(); tick();
    checks++; if (state !== 3'd6 || fault !== 1'b1) begin errors++; $display("FAIL to_fault_hold: got state %0d fault %b exp state 6 fault 1", state, fault); end
    nreset = 1'b1;
    tick();
    exp_ret = 16'd0;
    checks++; if (state !== 3'd0 || strb !== 9'b000000000 || retire_count !== 16'd0) begin errors++; $display("FAIL to_reset: got state %0d strb %b retire %0d exp state 0 strb 000000000 retire 0", state, strb, retire_count); end
    nreset = 1'b0;
    tick();
    for (int i = 1; i <= 15; i++) tick();
    checks++; if (state !== 3'd1) begin errors++; $display("FAIL to_cycle16_state: got %0d exp 1", state); end
    fetch(32'hE0843003);
    checks++; if (state !== 3'd2 || fault !== 1'b0) begin errors++; $display("FAIL to_late_ack: got state %0d fault %b exp state 2 fault 0", state, fault); end
    tick(); tick(); tick();
    exp_ret++;
    ret_exp = PERF_EN ? exp_ret : 16'd0;
    checks++; if (state !== 3'd1 || retire_count !== ret_exp) begin errors++; $display("FAIL to_late_ack_done: got state %0d retire %0d exp state 1 retire %0d", state, retire_count, ret_exp); end
  endtask

  task automatic test_run_stop();
    fetch(32'hE0843003);
    run = 1'b0;
    tick();
    checks++; if (state !== 3'd3) begin errors++; $display("FAIL stop_exec_state: got %0d exp 3", state); end
    tick();
    checks++; if (state !== 3'd5 || strb !== 9'b000001100) begin errors++; $display("FAIL stop_wb: got state %0d strb %b exp state 5 strb 000001100", state, strb); end
    tick();
    exp_ret++;
    checks++; if (state !== 3'd0 || strb !== 9'b000000000) begin errors++; $display("FAIL stop_idle: got state %0d strb %b exp state 0 strb 000000000", state, strb); end
    tick();
    checks++; if (state !== 3'd0) begin errors++; $display("FAIL stop_idle_hold: got %0d exp 0", state); end
    run = 1'b1;
    tick();
    ret_exp = PERF_EN ? exp_ret : 16'd0;
    checks++; if (state !== 3'd1 || retire_count !== ret_exp) begin errors++; $display("FAIL stop_resume: got state %0d retire %0d exp state 1 retire %0d", state, retire_count, ret_exp); end
  endtask

  initial begin
    test_reset();
    test_dp_add();
    test_cond_skip();
    test_ldr_str();
    test_cmp_branch();
    test_timeout();
    test_run_stop();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
